// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared encodings, grid defaults and motion FSM state type.
package bomberman_pkg;
  localparam int GRID_W_DEF  = 15;
  localparam int GRID_H_DEF  = 13;
  localparam int COORD_W_DEF = 4;
  typedef enum logic [1:0] {
    FACE_UP    = 2'd0,
    FACE_DOWN  = 2'd1,
    FACE_LEFT  = 2'd2,
    FACE_RIGHT = 2'd3
  } facing_e;
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } motion_state_e;
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: free-running movement-rate counter; tick on the last count, cleared while disabled.
module move_tick_gen #(
  parameter int MOVE_PERIOD = 5000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(MOVE_PERIOD);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && (cnt_q == CW'(MOVE_PERIOD - 1));
    cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: tile movement with map walkability handshake, facing and one-shot bomb placement.
module player_motion_ctrl
  import bomberman_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int MOVE_PERIOD = 5000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic               x_moving,
  input  logic               xdir,
  input  logic               y_moving,
  input  logic               ydir,
  input  logic               bomb_key,
  output logic               map_req,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_valid,
  input  logic               map_blocked,
  input  logic               bomb_clear,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         facing,
  output logic               moved,
  output logic               bomb_place,
  output logic [COORD_W-1:0] bomb_x,
  output logic [COORD_W-1:0] bomb_y,
  output logic               bomb_active
);
  motion_state_e      state_q, state_d;
  facing_e            facing_q, facing_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] map_x_q, map_x_d, map_y_q, map_y_d;
  logic [COORD_W-1:0] bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
  logic               moved_q, moved_d, bomb_place_q, bomb_place_d;
  logic               bomb_active_q, bomb_active_d, key_q, key_d;
  logic [COORD_W-1:0] tx, ty;
  logic               in_grid, tick;
  move_tick_gen #(.MOVE_PERIOD(MOVE_PERIOD)) u_tick (
    .clock (clock),
    .resetn(resetn),
    .en    (enable),
    .tick  (tick)
  );
  // x axis wins; in_grid is low when nothing is held, so it also gates the request
  always_comb begin
    tx      = x_moving ? (xdir ? pos_x_q + 1'b1 : pos_x_q - 1'b1) : pos_x_q;
    ty      = (!x_moving && y_moving) ? (ydir ? pos_y_q + 1'b1 : pos_y_q - 1'b1) : pos_y_q;
    in_grid = x_moving ? (xdir ? pos_x_q != COORD_W'(GRID_W - 1) : pos_x_q != '0) :
              y_moving ? (ydir ? pos_y_q != COORD_W'(GRID_H - 1) : pos_y_q != '0) : 1'b0;
  end
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    map_x_d  = map_x_q;
    map_y_d  = map_y_q;
    moved_d  = 1'b0;
    facing_d = x_moving ? (xdir ? FACE_RIGHT : FACE_LEFT) :
               y_moving ? (ydir ? FACE_DOWN : FACE_UP) : facing_q;
    case (state_q)
      IDLE: if (tick && enable && in_grid) begin
        state_d = REQ;
        map_x_d = tx;
        map_y_d = ty;
      end
      REQ: if (!enable) begin
        state_d = IDLE;
      end else if (map_valid) begin
        state_d = IDLE;
        if (!map_blocked) begin
          pos_x_d = map_x_q;
          pos_y_d = map_y_q;
          moved_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    key_d         = bomb_key;
    bomb_place_d  = bomb_key && !key_q && enable && !bomb_active_q && !bomb_clear;
    bomb_active_d = bomb_clear ? 1'b0 : (bomb_place_d || bomb_active_q);
    bomb_x_d      = bomb_place_d ? pos_x_q : bomb_x_q;
    bomb_y_d      = bomb_place_d ? pos_y_q : bomb_y_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      facing_q      <= FACE_DOWN;
      pos_x_q       <= COORD_W'(START_X);
      pos_y_q       <= COORD_W'(START_Y);
      map_x_q       <= '0;
      map_y_q       <= '0;
      moved_q       <= 1'b0;
      bomb_place_q  <= 1'b0;
      bomb_active_q <= 1'b0;
      bomb_x_q      <= '0;
      bomb_y_q      <= '0;
      key_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      facing_q      <= facing_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      map_x_q       <= map_x_d;
      map_y_q       <= map_y_d;
      moved_q       <= moved_d;
      bomb_place_q  <= bomb_place_d;
      bomb_active_q <= bomb_active_d;
      bomb_x_q      <= bomb_x_d;
      bomb_y_q      <= bomb_y_d;
      key_q         <= key_d;
    end
  end
  assign map_req     = (state_q == REQ);
  assign map_x       = map_x_q;
  assign map_y       = map_y_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign facing      = facing_q;
  assign moved       = moved_q;
  assign bomb_place  = bomb_place_q;
  assign bomb_x      = bomb_x_q;
  assign bomb_y      = bomb_y_q;
  assign bomb_active = bomb_active_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: scoreboard bench; stimulus queues expected req/move/bomb events, a monitor pops them.
module tb_player_motion_ctrl;
  localparam logic [1:0] EV_REQ = 2'd0, EV_MOV = 2'd1, EV_BMB = 2'd2;
  typedef struct {
    logic [1:0] k;
    logic [3:0] x;
    logic [3:0] y;
  } ev_t;
  logic       clock, resetn, enable, x_moving, xdir, y_moving, ydir, bomb_key;
  logic       map_req, resp_valid, man_valid, map_valid, blk, bomb_clear;
  logic [3:0] map_x, map_y, pos_x, pos_y, bomb_x, bomb_y;
  logic [1:0] facing;
  logic       moved, bomb_place, bomb_active, resp_on;
  int         resp_delay, checks, errors, mx, my;
  ev_t        q[$];
  assign map_valid = resp_valid | man_valid;
  player_motion_ctrl #(.GRID_W(15), .GRID_H(13), .COORD_W(4), .START_X(1), .START_Y(1), .MOVE_PERIOD(4)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .x_moving(x_moving), .xdir(xdir),
    .y_moving(y_moving), .ydir(ydir), .bomb_key(bomb_key), .map_req(map_req), .map_x(map_x),
    .map_y(map_y), .map_valid(map_valid), .map_blocked(blk), .bomb_clear(bomb_clear),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .moved(moved), .bomb_place(bomb_place),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_active(bomb_active)
  );
  always #5 clock = ~clock;
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [1:0] k, input int x, input int y);
    q.push_back('{k, 4'(x), 4'(y)});
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask
  task automatic wait_req();
    int n = 0;
    while (!map_req && n < 40) begin
      @(negedge clock);
      n++;
    end
    cmp("req_timeout", int'(map_req), 1);
  endtask
  task automatic release_keys();
    x_moving = 0;
    y_moving = 0;
  endtask
  task automatic move_n(input logic xm, input logic xd, input logic ym, input logic yd, input int n, input logic b);
    int tx = mx, ty = my;
    for (int i = 0; i < n; i++) begin
      tx += xm ? (xd ? 1 : -1) : 0;
      ty += (!xm && ym) ? (yd ? 1 : -1) : 0;
      push(EV_REQ, tx, ty);
      if (!b) begin
        push(EV_MOV, tx, ty);
        mx = tx;
        my = ty;
      end
    end
    blk = b;
    x_moving = xm; xdir = xd; y_moving = ym; ydir = yd;
    wait_drain();
    release_keys();
    if (b) repeat (6) @(negedge clock);
    cmp("pos_x", int'(pos_x), mx);
    cmp("pos_y", int'(pos_y), my);
  endtask
  initial begin
    resp_valid = 0;
    forever begin
      @(posedge clock); #1;
      if (resp_on && map_req) begin
        repeat (resp_delay) @(posedge clock);
        #1 resp_valid = 1;
        @(posedge clock); #1 resp_valid = 0;
      end
    end
  end
  initial begin
    logic prev_req = 0;
    forever begin
      @(posedge clock); #1;
      if (map_req && !prev_req) mon_chk(EV_REQ, map_x, map_y, "req");
      if (moved) mon_chk(EV_MOV, pos_x, pos_y, "move");
      if (bomb_place) mon_chk(EV_BMB, bomb_x, bomb_y, "bomb");
      prev_req = map_req;
    end
  end
  task automatic mon_chk(input logic [1:0] k, input logic [3:0] x, input logic [3:0] y, input string name);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s actual=(%0d,%0d) expected=none", name, x, y);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.x != x || e.y != y) begin
        errors++;
        $display("FAIL %s actual=kind%0d(%0d,%0d) expected=kind%0d(%0d,%0d)", name, k, x, y, e.k, e.x, e.y);
      end
    end
  endtask
  initial begin
    clock = 0; resetn = 0; enable = 1; x_moving = 0; xdir = 0; y_moving = 0; ydir = 0;
    bomb_key = 0; bomb_clear = 0; blk = 0; man_valid = 0; resp_on = 1; resp_delay = 2;
    checks = 0; errors = 0; mx = 1; my = 1;
    repeat (3) @(negedge clock);
    resetn = 1;
    @(negedge clock);
    cmp("rst_pos_x", int'(pos_x), 1);
    cmp("rst_pos_y", int'(pos_y), 1);
    cmp("rst_facing", int'(facing), 1);
    cmp("rst_map_req", int'(map_req), 0);
    cmp("rst_bomb_active", int'(bomb_active), 0);
    cmp("rst_bomb_x", int'(bomb_x), 0);
    cmp("rst_moved", int'(moved), 0);
    move_n(1, 1, 0, 0, 2, 0);
    move_n(0, 0, 1, 1, 1, 1);
    move_n(1, 0, 0, 0, 3, 0);
    cmp("facing_left", int'(facing), 2);
    x_moving = 1; xdir = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      cmp("edge_no_req", int'(map_req), 0);
    end
    release_keys();
    move_n(1, 1, 0, 0, 3, 0);
    move_n(0, 0, 1, 1, 2, 0);
    blk = 1;
    push(EV_REQ, 2, 3);
    x_moving = 1; xdir = 0; y_moving = 1; ydir = 1;
    @(negedge clock);
    cmp("prio_facing", int'(facing), 2);
    wait_drain();
    release_keys();
    repeat (6) @(negedge clock);
    cmp("prio_pos_x", int'(pos_x), 3);
    cmp("prio_pos_y", int'(pos_y), 3);
    blk = 0; resp_delay = 10;
    push(EV_REQ, 4, 3);
    push(EV_MOV, 4, 3);
    x_moving = 1; xdir = 1;
    wait_req();
    for (int i = 0; i < 10; i++) begin
      cmp("stall_req", int'(map_req), 1);
      cmp("stall_map_x", int'(map_x), 4);
      cmp("stall_map_y", int'(map_y), 3);
      @(negedge clock);
    end
    wait_drain();
    release_keys();
    resp_delay = 2;
    cmp("stall_pos_x", int'(pos_x), 4);
    bomb_key = 1;
    push(EV_BMB, 4, 3);
    repeat (20) @(negedge clock);
    cmp("bomb_active", int'(bomb_active), 1);
    cmp("bomb_once", q.size(), 0);
    bomb_key = 0;
    repeat (2) @(negedge clock);
    bomb_key = 1;
    repeat (5) @(negedge clock);
    cmp("bomb_still_active", int'(bomb_active), 1);
    bomb_key = 0;
    repeat (2) @(negedge clock);
    bomb_key = 1; bomb_clear = 1;
    @(negedge clock);
    bomb_clear = 0;
    cmp("clear_wins_active", int'(bomb_active), 0);
    cmp("clear_wins_place", int'(bomb_place), 0);
    repeat (4) @(negedge clock);
    cmp("held_no_rearm", int'(bomb_active), 0);
    bomb_key = 0;
    @(negedge clock);
    bomb_key = 1;
    push(EV_BMB, 4, 3);
    wait_drain();
    cmp("rearm_active", int'(bomb_active), 1);
    bomb_key = 0;
    resp_on = 0;
    push(EV_REQ, 5, 3);
    x_moving = 1; xdir = 1;
    wait_req();
    release_keys();
    enable = 0; man_valid = 1;
    @(negedge clock);
    man_valid = 0; enable = 1;
    cmp("dis_map_req", int'(map_req), 0);
    cmp("dis_pos_x", int'(pos_x), 4);
    repeat (6) @(negedge clock);
    cmp("dis_pos_x_later", int'(pos_x), 4);
    push(EV_REQ, 3, 3);
    x_moving = 1; xdir = 0;
    wait_req();
    release_keys();
    resetn = 0;
    #1;
    cmp("arst_pos_x", int'(pos_x), 1);
    cmp("arst_pos_y", int'(pos_y), 1);
    cmp("arst_facing", int'(facing), 1);
    cmp("arst_map_req", int'(map_req), 0);
    cmp("arst_bomb_active", int'(bomb_active), 0);
    @(negedge clock);
    resetn = 1;
    repeat (4) @(negedge clock);
    cmp("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
